// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches to instruction
// memory over req/gnt/rvalid, buffers returned words tagged with their PC in an
// in-order FIFO, and hands them to decode with a valid/ready handshake.
// A redirect flushes the queue and drops responses still in flight.
// Optional build macro: IPQ_PERF_CNT_EN adds saturating 16-bit counters for
// empty cycles (perf_empty_cycles) and dropped responses (perf_discards).
module instr_prefetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [ADDR_W-1:0]       imem_addr,
    input  logic                    imem_gnt,
    input  logic                    imem_rvalid,
    input  logic [DATA_W-1:0]       imem_rdata,
    input  logic                    redirect_valid,
    input  logic [ADDR_W-1:0]       redirect_pc,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [DATA_W-1:0]       inst_data,
    output logic [ADDR_W-1:0]       inst_pc,
    output logic [$clog2(DEPTH):0]  occupancy
`ifdef IPQ_PERF_CNT_EN
    ,
    output logic [15:0]             perf_empty_cycles,
    output logic [15:0]             perf_discards
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0]  count_reg, count_next;
    logic [CNT_W-1:0]  outst_reg, outst_next;
    logic [CNT_W-1:0]  discard_reg, discard_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [ADDR_W-1:0] resp_pc_reg, resp_pc_next;
    logic [DATA_W-1:0] head_data_reg, head_data_next;
    logic [ADDR_W-1:0] head_pc_reg, head_pc_next;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [DEPTH-1:0]  entry_we;

    logic [CNT_W:0]    inflight;
    logic [CNT_W-1:0]  count_after_pop;
    logic              fire;
    logic              push;
    logic              pop;
    logic              drop;

    // Credit check covers both queued words and requests still owed a response,
    // so a response can always be stored even when the queue is not popping.
    assign inflight  = {1'b0, count_reg} + {1'b0, outst_reg};
    assign imem_req  = !reset && !redirect_valid && (inflight < (CNT_W+1)'(DEPTH));
    assign imem_addr = fetch_pc_reg;
    assign fire      = imem_req && imem_gnt;

    assign pop  = (count_reg != '0) && inst_ready && !redirect_valid;
    assign push = imem_rvalid && !redirect_valid && (discard_reg == '0);
    assign drop = imem_rvalid && !push;

    assign inst_valid = (count_reg != '0);
    assign inst_data  = head_data_reg;
    assign inst_pc    = head_pc_reg;
    assign occupancy  = count_reg;

    // One write enable per FIFO slot, selected by the write pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign entry_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    // Next-state for counters, pointers, PCs and the registered head view.
    always_comb begin
        count_next      = count_reg;
        outst_next      = outst_reg + CNT_W'(fire) - CNT_W'(imem_rvalid);
        discard_next    = discard_reg;
        rd_ptr_next     = rd_ptr_reg + PTR_W'(pop);
        wr_ptr_next     = wr_ptr_reg + PTR_W'(push);
        fetch_pc_next   = fetch_pc_reg;
        resp_pc_next    = resp_pc_reg;
        head_data_next  = head_data_reg;
        head_pc_next    = head_pc_reg;
        count_after_pop = count_reg - CNT_W'(pop);

        if (redirect_valid) begin
            count_next    = '0;
            discard_next  = outst_reg - CNT_W'(imem_rvalid);
            wr_ptr_next   = rd_ptr_reg;
            fetch_pc_next = redirect_pc;
            resp_pc_next  = redirect_pc;
        end else begin
            count_next = count_after_pop + CNT_W'(push);
            if (imem_rvalid && (discard_reg != '0))
                discard_next = discard_reg - 1'b1;
            if (fire)
                fetch_pc_next = fetch_pc_reg + ADDR_W'(4);
            if (push)
                resp_pc_next = resp_pc_reg + ADDR_W'(4);
            // Head comes straight from the response when it lands in an
            // otherwise-empty queue; when empty the head registers hold.
            if (count_next != '0) begin
                if (push && (count_after_pop == '0)) begin
                    head_data_next = imem_rdata;
                    head_pc_next   = resp_pc_reg;
                end else begin
                    head_data_next = mem_data[rd_ptr_next];
                    head_pc_next   = mem_pc[rd_ptr_next];
                end
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg     <= '0;
            outst_reg     <= '0;
            discard_reg   <= '0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            fetch_pc_reg  <= RESET_PC;
            resp_pc_reg   <= RESET_PC;
            head_data_reg <= '0;
            head_pc_reg   <= '0;
        end else begin
            count_reg     <= count_next;
            outst_reg     <= outst_next;
            discard_reg   <= discard_next;
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            fetch_pc_reg  <= fetch_pc_next;
            resp_pc_reg   <= resp_pc_next;
            head_data_reg <= head_data_next;
            head_pc_reg   <= head_pc_next;
        end
    end

    // FIFO storage: each slot captures {rdata, resp_pc} when selected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_we[i]) begin
                    mem_data[i] <= imem_rdata;
                    mem_pc[i]   <= resp_pc_reg;
                end
            end
        end
    end

`ifdef IPQ_PERF_CNT_EN
    // Saturating performance counters; only reset clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_empty_cycles <= '0;
            perf_discards     <= '0;
        end else begin
            if ((count_reg == '0) && (perf_empty_cycles != 16'hFFFF))
                perf_empty_cycles <= perf_empty_cycles + 16'd1;
            if (drop && (perf_discards != 16'hFFFF))
                perf_discards <= perf_discards + 16'd1;
        end
    end
`else
    // Drop indication only feeds the performance counters.
    logic drop_unused;
    assign drop_unused = drop;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed testbench for instr_prefetch_queue (DEPTH=4, RESET_PC=0).
// Instruction memory returns 32'hD000_0000 | addr for every granted address.
module tb_instr_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [2:0]  occupancy;
`ifdef IPQ_PERF_CNT_EN
    logic [15:0] perf_empty_cycles;
    logic [15:0] perf_discards;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] pending[$];

    instr_prefetch_queue #(
        .DEPTH(4), .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_data(inst_data),
        .inst_pc(inst_pc),
        .occupancy(occupancy)
`ifdef IPQ_PERF_CNT_EN
        ,
        .perf_empty_cycles(perf_empty_cycles),
        .perf_discards(perf_discards)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs; rv=1 returns the oldest granted address.
    task automatic drive(input logic g, input logic rv, input logic rdy,
                         input logic redir, input logic [31:0] rpc);
        imem_gnt       = g;
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rvalid    = 1'b0;
        if (rv) begin
            chk("resp_available", 64'(pending.size() != 0), 64'd1);
            if (pending.size() != 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hD000_0000 | pending.pop_front();
            end
        end
        #1;
    endtask

    // Advance one clock, recording any granted request for the memory model.
    task automatic tick();
        logic        fire;
        logic [31:0] a;
        fire = (imem_req === 1'b1) && (imem_gnt === 1'b1);
        a    = imem_addr;
        @(posedge clk);
        #1;
        if (fire) pending.push_back(a);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        redirect_valid = 0; redirect_pc = 0; inst_ready = 0;
        #12;
        chk("rst_valid", inst_valid, 0);
        chk("rst_req",   imem_req,   0);
        chk("rst_occ",   occupancy,  0);
        chk("rst_addr",  imem_addr,  32'h0);
        chk("rst_pc",    inst_pc,    32'h0);
        chk("rst_data",  inst_data,  32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Fill to capacity with rdy=0.
        drive(1, 0, 0, 0, 0); chk("fill_req0", imem_req, 1); chk("fill_addr0", imem_addr, 32'h0); tick();
        drive(1, 1, 0, 0, 0); chk("fill_req1", imem_req, 1); chk("fill_addr1", imem_addr, 32'h4); tick();
        drive(1, 1, 0, 0, 0); chk("fill_req2", imem_req, 1); chk("fill_addr2", imem_addr, 32'h8); tick();
        drive(1, 1, 0, 0, 0); chk("fill_req3", imem_req, 1); chk("fill_addr3", imem_addr, 32'hC); tick();
        drive(1, 1, 0, 0, 0); chk("fill_req_full", imem_req, 0); tick();

        // Drain in order; grant held low for 5 cycles to check stall.
        drive(1, 0, 1, 0, 0);
        chk("full_req", imem_req, 0); chk("full_occ", occupancy, 4); chk("full_valid", inst_valid, 1);
        chk("drain_pc0", inst_pc, 32'h0); chk("drain_data0", inst_data, 32'hD000_0000); tick();
        drive(0, 0, 1, 0, 0);
        chk("drain_pc1", inst_pc, 32'h4); chk("drain_data1", inst_data, 32'hD000_0004);
        chk("stall_req1", imem_req, 1); chk("stall_addr1", imem_addr, 32'h10); tick();
        drive(0, 0, 1, 0, 0);
        chk("drain_pc2", inst_pc, 32'h8); chk("drain_data2", inst_data, 32'hD000_0008);
        chk("stall_req2", imem_req, 1); chk("stall_addr2", imem_addr, 32'h10); tick();
        drive(0, 0, 1, 0, 0);
        chk("drain_pc3", inst_pc, 32'hC); chk("drain_data3", inst_data, 32'hD000_000C);
        chk("stall_req3", imem_req, 1); chk("stall_addr3", imem_addr, 32'h10); tick();
        drive(0, 0, 1, 0, 0);
        chk("empty_valid", inst_valid, 0); chk("empty_occ", occupancy, 0);
        chk("empty_hold_pc", inst_pc, 32'hC);
        chk("stall_req4", imem_req, 1); chk("stall_addr4", imem_addr, 32'h10); tick();
        drive(0, 0, 1, 0, 0);
        chk("stall_req5", imem_req, 1); chk("stall_addr5", imem_addr, 32'h10); tick();
        drive(1, 0, 0, 0, 0);
        chk("grant_addr", imem_addr, 32'h10); tick();
        drive(1, 1, 0, 0, 0);
        chk("post_grant_addr", imem_addr, 32'h14); tick();

        // Queue holds 1, two in flight, then redirect to 0x100.
        drive(1, 0, 0, 0, 0);
        chk("pre_redir_occ", occupancy, 1); chk("pre_redir_pc", inst_pc, 32'h10);
        chk("pre_redir_data", inst_data, 32'hD000_0010); chk("pre_redir_addr", imem_addr, 32'h18); tick();
        drive(1, 0, 0, 1, 32'h100);
        chk("redir_req", imem_req, 0); tick();
        drive(1, 1, 0, 0, 0);
        chk("redir_valid", inst_valid, 0); chk("redir_occ", occupancy, 0);
        chk("redir_req_next", imem_req, 1); chk("redir_addr", imem_addr, 32'h100); tick();
        drive(0, 1, 0, 0, 0);
        chk("redir_addr2", imem_addr, 32'h104); tick();
        drive(0, 1, 0, 0, 0);
        chk("drop_valid", inst_valid, 0); tick();
        drive(1, 0, 0, 0, 0);
        chk("redir_first_valid", inst_valid, 1); chk("redir_first_pc", inst_pc, 32'h100);
        chk("redir_first_data", inst_data, 32'hD000_0100); chk("redir_addr3", imem_addr, 32'h104); tick();

        // Build count=3, outstanding=1, then push and pop together.
        drive(1, 1, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0); tick();
        drive(1, 1, 1, 0, 0);
        chk("pp_occ_before", occupancy, 3); chk("pp_req_before", imem_req, 0);
        chk("pp_pc_before", inst_pc, 32'h100); tick();
        drive(1, 0, 0, 0, 0);
        chk("pp_occ_after", occupancy, 3); chk("pp_pc_after", inst_pc, 32'h104);
        chk("pp_data_after", inst_data, 32'hD000_0104);
        chk("pp_req_after", imem_req, 1); chk("pp_addr_after", imem_addr, 32'h110); tick();

        // Mid-operation reset with 3 queued and 1 outstanding.
        drive(0, 0, 0, 0, 0);
        chk("mr_occ_before", occupancy, 3); chk("mr_req_before", imem_req, 0);
        reset = 1'b1;
        #1;
        chk("mr_valid", inst_valid, 0); chk("mr_req", imem_req, 0);
        chk("mr_occ", occupancy, 0); chk("mr_addr", imem_addr, 32'h0);
        pending.delete();
        tick();
        reset = 1'b0;
        drive(1, 0, 0, 0, 0);
        chk("mr_restart_req", imem_req, 1); chk("mr_restart_addr", imem_addr, 32'h0); tick();
        drive(0, 0, 0, 0, 0);
        chk("mr_next_addr", imem_addr, 32'h4); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
